// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller. It reads the PC register,
// issues one instruction-memory request at a time and buffers the returned
// word for decode. It also drives the PC register load port for the reset
// vector, sequential advance and branch/jump redirects.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    state_t      state, state_nx;
    logic        drop, drop_nx;
    logic [31:0] req_pc;
    logic [31:0] pc_word;
    logic        grant_take;
    logic        capture;
    logic        release_buf;

    // Low PC bits are never meaningful for a word fetch.
    assign pc_word   = pc_in & WORD_MASK;
    assign imem_addr = pc_word;

    // State register and the "discard the in-flight response" flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nx;
            drop  <= drop_nx;
        end
    end

    // Request address capture and the decode-facing instruction buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc     <= '0;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            if (grant_take)
                req_pc <= imem_addr;
            if (capture) begin
                inst_out   <= imem_rdata;
                inst_pc    <= req_pc;
                inst_valid <= 1'b1;
            end else if (release_buf) begin
                inst_valid <= 1'b0;
            end
        end
    end

    // Next state, PC load port and memory request. A redirect overrides the
    // sequential behaviour of every state; reset masks the strobes.
    always_comb begin
        state_nx    = state;
        drop_nx     = drop;
        pc_ena      = 1'b0;
        pc_next     = pc_word + 32'd4;
        imem_req    = 1'b0;
        grant_take  = 1'b0;
        capture     = 1'b0;
        release_buf = 1'b0;

        case (state)
            IDLE: begin
                pc_ena   = 1'b1;
                pc_next  = RESET_PC;
                state_nx = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    grant_take = 1'b1;
                    pc_ena     = 1'b1;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        capture  = 1'b1;
                        state_nx = FULL;
                    end
                end
            end
            FULL: begin
                if (inst_valid && inst_ready) begin
                    release_buf = 1'b1;
                    state_nx    = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (br_taken) begin
            pc_ena     = 1'b1;
            pc_next    = br_target & WORD_MASK;
            imem_req   = 1'b0;
            grant_take = 1'b0;
            capture    = 1'b0;
            case (state)
                IDLE: state_nx = REQ;
                REQ:  state_nx = REQ;
                WAIT: begin
                    // A response arriving alongside the redirect is simply
                    // dropped now; otherwise remember to drop it later.
                    if (imem_rvalid) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        drop_nx  = 1'b1;
                        state_nx = WAIT;
                    end
                end
                FULL: begin
                    release_buf = 1'b1;
                    state_nx    = REQ;
                end
                default: state_nx = IDLE;
            endcase
        end

        if (!rst) begin
            pc_ena   = 1'b0;
            imem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: PC register and memory models around the DUT, a
// transaction-level reference model checked every cycle, and directed
// scenarios with literal expectations.
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_VEC = 32'h0040_0000;
    localparam logic [31:0] MASK    = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mem_lat;

    ifetch_ctrl #(.RESET_PC(RST_VEC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_next    (pc_next),
        .pc_ena     (pc_ena),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PC register (not reset by the fetch controller's reset)
    logic [31:0] pc_reg = 32'h0;
    always @(posedge clk) if (pc_ena) pc_reg <= pc_next;
    assign pc_in = pc_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Memory: response data is 0xAAAA0000 + addr[7:0], mem_lat cycles after grant.
    int          due_q[$];
    logic [31:0] dat_q[$];
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst && imem_req && imem_gnt) begin
                due_q.push_back(cyc + mem_lat);
                dat_q.push_back(32'hAAAA_0000 + {24'h0, imem_addr[7:0]});
            end
            @(posedge clk);
            #1;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Reference model: outstanding request, squash flag, buffer contents and
    // the program-order address of the next instruction decode should see.
    logic        m_prev_rst = 1'b0;
    logic        m_out = 1'b0, m_sq = 1'b0, m_vld = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0, m_pc = '0;
    logic [31:0] prog_pc = '0;
    logic [31:0] hs_pc[$];
    logic [31:0] hs_out[$];
    int          hs_cyc[$];

    initial begin
        logic        first, req_e, ena_e, nv;
        logic [31:0] nxt_e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_pc_ena", pc_ena, 0);
                chk("rst_imem_req", imem_req, 0);
                chk("rst_inst_valid", inst_valid, 0);
                chk("rst_inst_out", inst_out, 0);
                chk("rst_inst_pc", inst_pc, 0);
                m_out = 0; m_sq = 0; m_vld = 0; m_prev_rst = 0;
            end else begin
                first = !m_prev_rst;
                if (first) prog_pc = RST_VEC;
                req_e = !br_taken && !first && !m_out && !m_vld;
                chk("imem_req", imem_req, req_e);
                chk("imem_addr", imem_addr, pc_in & MASK);
                ena_e = 1'b0;
                nxt_e = '0;
                if (br_taken) begin
                    ena_e = 1'b1; nxt_e = br_target & MASK;
                end else if (first) begin
                    ena_e = 1'b1; nxt_e = RST_VEC;
                end else if (req_e && imem_gnt) begin
                    ena_e = 1'b1; nxt_e = (pc_in & MASK) + 32'd4;
                end
                chk("pc_ena", pc_ena, ena_e);
                if (ena_e) chk("pc_next", pc_next, nxt_e);
                chk("inst_valid", inst_valid, m_vld);
                if (m_vld) begin
                    chk("inst_out", inst_out, m_data);
                    chk("inst_pc", inst_pc, m_pc);
                end
                if (m_vld && inst_ready && !br_taken) begin
                    chk("program_order", inst_pc, prog_pc);
                    hs_pc.push_back(inst_pc);
                    hs_out.push_back(inst_out);
                    hs_cyc.push_back(cyc);
                    prog_pc = prog_pc + 32'd4;
                end
                nv = m_vld && !inst_ready && !br_taken;
                if (m_out && imem_rvalid) begin
                    if (!m_sq && !br_taken) begin
                        nv = 1'b1; m_data = imem_rdata; m_pc = m_addr;
                    end
                    m_out = 0; m_sq = 0;
                end else if (m_out && br_taken) begin
                    m_sq = 1;
                end
                if (req_e && imem_gnt) begin
                    m_out = 1; m_sq = 0; m_addr = pc_in & MASK;
                end
                m_vld = nv;
                if (br_taken) prog_pc = br_target & MASK;
                m_prev_rst = 1'b1;
            end
        end
    end

    // kind 0: grant, 1: inst_valid, 2: imem_req (stops at a negedge)
    task automatic wait_for(input int kind, input string name);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            case (kind)
                0:       got = imem_req && imem_gnt;
                1:       got = inst_valid;
                default: got = imem_req;
            endcase
        end
        if (!got) timeout(name);
    endtask

    task automatic wait_hs(input int n, input string name);
        bit got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            got = (hs_pc.size() >= n);
        end
        if (!got) timeout(name);
    endtask

    task automatic hs_clear();
        hs_pc.delete(); hs_out.delete(); hs_cyc.delete();
    endtask

    initial begin
        logic [31:0] sv_out, sv_pc;
        rst = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
        br_taken = 1'b0; br_target = 32'h0; mem_lat = 1;
        repeat (3) @(posedge clk);

        // Reset release and the first three sequential fetches
        #1 rst = 1'b1;
        hs_clear();
        @(negedge clk);
        chk("release_pc_ena", pc_ena, 1);
        chk("release_pc_next", pc_next, 32'h0040_0000);
        wait_hs(3, "first_fetches");
        if (hs_pc.size() >= 3) begin
            chk("fetch0_pc", hs_pc[0], 32'h0040_0000);
            chk("fetch0_out", hs_out[0], 32'hAAAA_0000);
            chk("fetch1_pc", hs_pc[1], 32'h0040_0004);
            chk("fetch1_out", hs_out[1], 32'hAAAA_0004);
            chk("fetch2_pc", hs_pc[2], 32'h0040_0008);
            chk("fetch2_out", hs_out[2], 32'hAAAA_0008);
            chk("spacing01", hs_cyc[1] - hs_cyc[0], 3);
            chk("spacing12", hs_cyc[2] - hs_cyc[1], 3);
        end

        // Decode stalls for 5 cycles while the buffer is full
        @(posedge clk); #1 inst_ready = 1'b0;
        wait_for(1, "stall_valid");
        sv_out = inst_out; sv_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", inst_valid, 1);
            chk("stall_out", inst_out, sv_out);
            chk("stall_pc", inst_pc, sv_pc);
            chk("stall_req", imem_req, 0);
            chk("stall_pc_ena", pc_ena, 0);
        end
        @(posedge clk); #1 inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("resume_req", imem_req, 1);

        // Redirect while waiting: in-flight word dropped
        @(posedge clk); #1 mem_lat = 2;
        wait_for(0, "wait_br_grant");
        @(posedge clk); #1 br_taken = 1'b1; br_target = 32'h0040_1003;
        @(negedge clk);
        chk("wait_br_pc_ena", pc_ena, 1);
        chk("wait_br_pc_next", pc_next, 32'h0040_1000);
        @(posedge clk); #1 br_taken = 1'b0; mem_lat = 1;
        @(negedge clk);
        chk("wait_br_drop_valid", inst_valid, 0);
        @(negedge clk);
        chk("wait_br_valid", inst_valid, 0);
        chk("wait_br_req", imem_req, 1);
        chk("wait_br_addr", imem_addr, 32'h0040_1000);

        // Redirect in REQ coincident with a grant
        @(posedge clk); #1 imem_gnt = 1'b0;
        wait_for(2, "req_br_req");
        @(posedge clk); #1 imem_gnt = 1'b1; br_taken = 1'b1; br_target = 32'h0040_2000;
        @(negedge clk);
        chk("req_br_req", imem_req, 0);
        chk("req_br_pc_ena", pc_ena, 1);
        chk("req_br_pc_next", pc_next, 32'h0040_2000);
        @(posedge clk); #1 br_taken = 1'b0;
        @(negedge clk);
        chk("req_br_next_req", imem_req, 1);
        chk("req_br_next_addr", imem_addr, 32'h0040_2000);
        chk("req_br_next_pc", pc_next, 32'h0040_2004);

        // Redirect in FULL with decode not ready
        @(posedge clk); #1 inst_ready = 1'b0;
        wait_for(1, "full_br_valid");
        @(posedge clk); #1 br_taken = 1'b1; br_target = 32'h0040_3000;
        @(negedge clk);
        chk("full_br_valid_hold", inst_valid, 1);
        @(posedge clk); #1 br_taken = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        chk("full_br_valid_clr", inst_valid, 0);
        chk("full_br_req", imem_req, 1);
        chk("full_br_addr", imem_addr, 32'h0040_3000);

        // PC wrap at the top of the address space
        @(posedge clk); #1 inst_ready = 1'b0;
        wait_for(1, "wrap_valid");
        @(posedge clk); #1 br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        @(posedge clk); #1 br_taken = 1'b0; inst_ready = 1'b1;
        hs_clear();
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_ena", pc_ena, 1);
        chk("wrap_pc_next", pc_next, 32'h0000_0000);
        wait_hs(2, "wrap_fetches");
        if (hs_pc.size() >= 2) begin
            chk("wrap_fetch0_pc", hs_pc[0], 32'hFFFF_FFFC);
            chk("wrap_fetch0_out", hs_out[0], 32'hAAAA_00FC);
            chk("wrap_fetch1_pc", hs_pc[1], 32'h0000_0000);
            chk("wrap_fetch1_out", hs_out[1], 32'hAAAA_0000);
        end

        // Reset during WAIT; the late response lands after release
        @(posedge clk); #1 mem_lat = 3;
        wait_for(0, "rst_grant");
        @(posedge clk); #1 rst = 1'b0; mem_lat = 1;
        hs_clear();
        @(negedge clk);
        chk("midrst_valid", inst_valid, 0);
        chk("midrst_req", imem_req, 0);
        chk("midrst_pc_ena", pc_ena, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rerelease_pc_ena", pc_ena, 1);
        chk("rerelease_pc_next", pc_next, 32'h0040_0000);
        wait_hs(1, "restart_fetch");
        if (hs_pc.size() >= 1) begin
            chk("restart_pc", hs_pc[0], 32'h0040_0000);
            chk("restart_out", hs_out[0], 32'hAAAA_0000);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
